cordic_sincos_ctrl: RTL and testbench
=====================================

# cordic_sincos_ctrl

Upstream sequencer for the iterative `cordic` core in circular rotation mode (`mode` = 0). It accepts an angle request over a valid/ready handshake and reduces the angle to the core's ±45.00° convergence range. It then launches the core with gain-precompensated operands and waits for `finish`. Finally it applies the quadrant correction and returns (cos, sin) over a valid/ready handshake. Angles are in 0.01° units; results are Q1.12 (4096 = 1.0).

## Interface
- `TIMEOUT`, default 32: cycles in WAIT without `cd_finish` before an error result is issued.
- `K_INIT`, default 2487: x preload, round(0.60725·4096).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset. Share it with the `cordic` core.
- `in_valid` in 1: angle request valid.
- `in_ready` out 1: high only in IDLE.
- `in_angle` in 16: unsigned angle, 0.01° units, 0..65535.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: consumer accepts.
- `out_cos` out 14: signed Q1.12 cosine.
- `out_sin` out 14: signed Q1.12 sine.
- `out_err` out 1: core timed out; `out_cos` and `out_sin` are 0.
- `cd_start` out 1: one-cycle start pulse to the core.
- `cd_mode` out 4: constant 0.
- `cd_x`, `cd_y`, `cd_z` out 14 each: core operands, two's complement.
- `cd_x_out`, `cd_y_out` in 14 each: core results.
- `cd_finish` in 1: core done pulse.

## Operation
- FSM states: IDLE → REDUCE → LAUNCH → WAIT → OUT → IDLE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, register `in_angle` and go to REDUCE.
- REDUCE (one cycle):
  - `a` = `in_angle` ≥ 36000 ? `in_angle` − 36000 : `in_angle`. A single subtract suffices, since 65535 − 36000 < 36000.
  - `k` = floor(`a` / 9000) by compare chain, range 0..3. `r` = `a` − 9000·`k`.
  - If `r` > 4500: `z` = `r` − 9000 and `k` = (`k` + 1) mod 4. Otherwise `z` = `r`.
  - Result: `z` ∈ [−4500, 4500], `k` registered.
- LAUNCH:
  - `cd_start` = 1 for exactly this cycle.
  - `cd_x` = `K_INIT`, `cd_y` = 0, `cd_z` = `z`.
- WAIT:
  - `cd_x`, `cd_y`, `cd_z`, `cd_mode` are held stable throughout.
  - The timeout counter starts at 0 and increments each cycle.
  - On `cd_finish`, capture the corrected result (below) and go to OUT.
  - If the counter reaches `TIMEOUT` − 1 without `cd_finish`: `out_cos` = `out_sin` = 0, `out_err` = 1, go to OUT.
- Quadrant correction, with (x, y) = (`cd_x_out`, `cd_y_out`):
  - `k` = 0: (x, y)
  - `k` = 1: (−y, x)
  - `k` = 2: (−x, −y)
  - `k` = 3: (y, −x)
  - Magnitudes stay ≤ 4200, so negation never overflows 14 bits.
- OUT:
  - `out_valid` = 1; outputs stay stable until `out_valid` && `out_ready`, then go to IDLE.
  - There is no back-to-back acceptance: `in_ready` stays 0 until the cycle after the output handshake.
- A `cd_finish` arriving in any state other than WAIT is ignored.

## Timing
- Reset values (synchronous): state IDLE; `out_valid`, `out_err`, `cd_start` = 0; `out_cos`, `out_sin`, `cd_x`, `cd_y`, `cd_z`, `cd_mode` = 0; timeout counter = 0.
- `rst` in any state, including mid-WAIT, returns to IDLE on the next edge. No pending result is emitted.
- Request accepted at edge T:
  - REDUCE at T+1.
  - `cd_start` high during cycle T+2.
  - `cd_finish` seen at edge F gives `out_valid` high from F+1.
  - Total latency = core latency + 3 cycles.
- Timeout: `out_valid` rises `TIMEOUT` + 3 cycles after acceptance.
- `out_ready` may be high before `out_valid`; the handshake completes in the first cycle `out_valid` is high.

## Structure
- Shared package `cordic_pkg`:
  - Constants: `ANG_360` = 36000, `ANG_90` = 9000, `ANG_45` = 4500, `K_Q12` = 2487, `Q12_ONE` = 4096.
  - State enum `sc_state_t`.
- One combinational sub-module, `cordic_range_reduce`:
  - Input: 16-bit angle.
  - Outputs: signed 14-bit `z` and 2-bit `k`.
  - Unit-testable on its own.

## Test plan
All values tolerate ±8 LSB.
- `in_angle` = 0 → `cd_z` = 0; result `out_cos` ≈ 4096, `out_sin` ≈ 0, `out_err` = 0.
- `in_angle` = 9000 → `k` = 1, `cd_z` = 0; result ≈ (0, 4096). `in_angle` = 27000 → ≈ (0, −4096).
- `in_angle` = 13500 → `k` = 1, `cd_z` = 4500; result ≈ (−2896, 2896). `in_angle` = 40000 → `cd_z` = 4000; result ≈ (3138, 2633).
- Stub core holds `cd_finish` at 0 → `out_valid` rises `TIMEOUT` + 3 cycles after acceptance, with `out_err` = 1 and (0, 0).
- `out_ready` held low 10 cycles after `out_valid` → outputs stable, `in_ready` = 0; new `in_valid` is not accepted until the cycle after the handshake.
- `rst` pulsed 3 cycles into WAIT → IDLE next edge, `out_valid` never rises; the next request completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state encoding and result payload for the CORDIC sin/cos sequencer.
// Angles are in 0.01 degree units; data is Q1.12 two's complement.
package cordic_pkg;

    localparam int unsigned ANG_W   = 16;
    localparam int unsigned DATA_W  = 14;
    localparam int unsigned ANG_360 = 36000;
    localparam int unsigned ANG_90  = 9000;
    localparam int unsigned ANG_45  = 4500;
    localparam int unsigned K_Q12   = 2487;
    localparam int unsigned Q12_ONE = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_LAUNCH,
        ST_WAIT,
        ST_OUT
    } sc_state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] cos_v;
        logic signed [DATA_W-1:0] sin_v;
    } sc_result_t;

    // Rotate the core's first-sector result back into quadrant k.
    function automatic sc_result_t quad_correct(
        input logic [1:0]               k,
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y
    );
        sc_result_t r;
        unique case (k)
            2'd0: begin r.cos_v = x;  r.sin_v = y;  end
            2'd1: begin r.cos_v = -y; r.sin_v = x;  end
            2'd2: begin r.cos_v = -x; r.sin_v = -y; end
            default: begin r.cos_v = y; r.sin_v = -x; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cordic_range_reduce.sv
// Folds a 0..65535 angle (0.01 deg) into a residual z in [-4500, 4500] plus a quadrant index k.
module cordic_range_reduce
    import cordic_pkg::*;
(
    input  logic [ANG_W-1:0]         angle_i,
    output logic signed [DATA_W-1:0] z_o,
    output logic [1:0]               k_o
);

    logic [ANG_W-1:0] a;
    logic [ANG_W-1:0] r;
    logic [1:0]       k;

    always_comb begin
        // One subtract is enough: 65535 - 36000 is already below 36000.
        a = (angle_i >= ANG_W'(ANG_360)) ? angle_i - ANG_W'(ANG_360) : angle_i;

        if (a >= ANG_W'(3 * ANG_90)) begin
            k = 2'd3;
            r = a - ANG_W'(3 * ANG_90);
        end else if (a >= ANG_W'(2 * ANG_90)) begin
            k = 2'd2;
            r = a - ANG_W'(2 * ANG_90);
        end else if (a >= ANG_W'(ANG_90)) begin
            k = 2'd1;
            r = a - ANG_W'(ANG_90);
        end else begin
            k = 2'd0;
            r = a;
        end

        // Upper half of a quadrant is reached from the next quadrant with a negative residual.
        if (r > ANG_W'(ANG_45)) begin
            z_o = DATA_W'(r - ANG_W'(ANG_90));
            k_o = k + 2'd1;
        end else begin
            z_o = DATA_W'(r);
            k_o = k;
        end
    end

endmodule

// File: rtl/cordic_sincos_ctrl.sv
// Sequencer around an iterative rotation-mode CORDIC core: range-reduces the angle, launches
// the core with gain-precompensated x, applies quadrant correction and returns (cos, sin).
module cordic_sincos_ctrl
    import cordic_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned K_INIT  = K_Q12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ANG_W-1:0]         in_angle,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_cos,
    output logic signed [DATA_W-1:0] out_sin,
    output logic                     out_err,
    output logic                     cd_start,
    output logic [3:0]               cd_mode,
    output logic signed [DATA_W-1:0] cd_x,
    output logic signed [DATA_W-1:0] cd_y,
    output logic signed [DATA_W-1:0] cd_z,
    input  logic signed [DATA_W-1:0] cd_x_out,
    input  logic signed [DATA_W-1:0] cd_y_out,
    input  logic                     cd_finish
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    sc_state_t                state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic [ANG_W-1:0]         angle_q, angle_d;
    logic [1:0]               k_q, k_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     cd_start_q, cd_start_d;
    logic signed [DATA_W-1:0] cd_x_q, cd_x_d;
    logic signed [DATA_W-1:0] cd_y_q, cd_y_d;
    logic signed [DATA_W-1:0] cd_z_q, cd_z_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_err_q, out_err_d;
    sc_result_t               res_q, res_d;

    logic signed [DATA_W-1:0] rr_z;
    logic [1:0]               rr_k;
    sc_result_t               corr;

    cordic_range_reduce u_reduce (
        .angle_i (angle_q),
        .z_o     (rr_z),
        .k_o     (rr_k)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            angle_q     <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            cd_start_q  <= 1'b0;
            cd_x_q      <= '0;
            cd_y_q      <= '0;
            cd_z_q      <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            angle_q     <= angle_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            cd_start_q  <= cd_start_d;
            cd_x_q      <= cd_x_d;
            cd_y_q      <= cd_y_d;
            cd_z_q      <= cd_z_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            res_q       <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        cd_start_d  = 1'b0;
        cd_x_d      = cd_x_q;
        cd_y_d      = cd_y_q;
        cd_z_d      = cd_z_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        res_d       = res_q;
        corr        = quad_correct(k_q, cd_x_out, cd_y_out);

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    angle_d = in_angle;
                    state_d = ST_REDUCE;
                end
            end
            // Operands are loaded here so cd_start and the operands appear together in LAUNCH.
            ST_REDUCE: begin
                k_d        = rr_k;
                cd_start_d = 1'b1;
                cd_x_d     = DATA_W'(K_INIT);
                cd_y_d     = '0;
                cd_z_d     = rr_z;
                state_d    = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cd_finish) begin
                    res_d       = corr;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d       = '0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign out_cos   = res_q.cos_v;
    assign out_sin   = res_q.sin_v;
    assign cd_start  = cd_start_q;
    assign cd_mode   = 4'd0;
    assign cd_x      = cd_x_q;
    assign cd_y      = cd_y_q;
    assign cd_z      = cd_z_q;

endmodule

// File: tb/tb_cordic_sincos_ctrl.sv
// Directed bench for cordic_sincos_ctrl; the CORDIC core is played by the stimulus itself,
// returning hand-computed first-sector (cos, sin) values after a chosen latency.
module tb_cordic_sincos_ctrl;

    localparam int TO = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_angle;
    logic               out_valid;
    logic               out_ready;
    logic signed [13:0] out_cos;
    logic signed [13:0] out_sin;
    logic               out_err;
    logic               cd_start;
    logic [3:0]         cd_mode;
    logic signed [13:0] cd_x;
    logic signed [13:0] cd_y;
    logic signed [13:0] cd_z;
    logic signed [13:0] cd_x_out;
    logic signed [13:0] cd_y_out;
    logic               cd_finish;

    int errors = 0;
    int checks = 0;
    logic flag;

    always #5 clk = ~clk;

    cordic_sincos_ctrl #(.TIMEOUT(TO), .K_INIT(2487)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cos   (out_cos),
        .out_sin   (out_sin),
        .out_err   (out_err),
        .cd_start  (cd_start),
        .cd_mode   (cd_mode),
        .cd_x      (cd_x),
        .cd_y      (cd_y),
        .cd_z      (cd_z),
        .cd_x_out  (cd_x_out),
        .cd_y_out  (cd_y_out),
        .cd_finish (cd_finish)
    );

    task automatic chk(input string tag, input string what,
                       input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    // Full transaction: accept, check launch operands, answer as the core after lat cycles, drain.
    task automatic request(input string tag, input int ang, input int ez,
                           input int cx, input int cy, input int ecos, input int esin,
                           input int lat);
        @(negedge clk);
        chk(tag, "in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_angle = 16'(ang);
        @(negedge clk);
        in_valid = 1'b0;
        chk(tag, "in_ready_busy", in_ready, 0);
        chk(tag, "start_early", cd_start, 0);
        @(negedge clk);
        chk(tag, "cd_start", cd_start, 1);
        chk(tag, "cd_z", cd_z, ez);
        chk(tag, "cd_x", cd_x, 2487);
        chk(tag, "cd_y", cd_y, 0);
        chk(tag, "cd_mode", cd_mode, 0);
        @(negedge clk);
        chk(tag, "start_pulse", cd_start, 0);
        repeat (lat) @(negedge clk);
        cd_x_out  = 14'(cx);
        cd_y_out  = 14'(cy);
        cd_finish = 1'b1;
        @(negedge clk);
        cd_finish = 1'b0;
        cd_x_out  = '0;
        cd_y_out  = '0;
        chk(tag, "out_valid", out_valid, 1);
        chk(tag, "out_err", out_err, 0);
        chk(tag, "out_cos", out_cos, ecos);
        chk(tag, "out_sin", out_sin, esin);
        chk(tag, "cd_z_held", cd_z, ez);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk(tag, "out_valid_drop", out_valid, 0);
        chk(tag, "in_ready_back", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_angle  = '0;
        out_ready = 1'b0;
        cd_finish = 1'b0;
        cd_x_out  = '0;
        cd_y_out  = '0;
        repeat (2) @(negedge clk);
        chk("reset", "out_valid", out_valid, 0);
        chk("reset", "out_err", out_err, 0);
        chk("reset", "cd_start", cd_start, 0);
        chk("reset", "cd_x", cd_x, 0);
        chk("reset", "cd_z", cd_z, 0);
        chk("reset", "out_cos", out_cos, 0);
        chk("reset", "in_ready", in_ready, 1);
        rst = 1'b0;

        request("a0",     0,     0,     4096, 0,     4096,  0,     3);
        request("a9000",  9000,  0,     4096, 0,     0,     4096,  5);
        request("a27000", 27000, 0,     4096, 0,     0,     -4096, 2);
        request("a13500", 13500, 4500,  2896, 2896,  -2896, 2896,  4);
        request("a40000", 40000, 4000,  3138, 2633,  3138,  2633,  4);
        request("a18000", 18000, 0,     4096, 0,     -4096, 0,     1);
        request("a4501",  4501,  -4499, 2897, -2895, 2895,  2897,  3);
        request("a35999", 35999, -1,    4096, -1,    4096,  -1,    3);
        request("a65535", 65535, 2535,  100,  200,   200,   -100,  0);

        // Core never finishes: error result after the timeout window.
        @(negedge clk);
        chk("timeout", "in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_angle = 16'd4500;
        flag = 1'b0;
        for (int j = 0; j <= TO + 1; j++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) flag = 1'b1;
        end
        chk("timeout", "early_valid", flag, 0);
        @(negedge clk);
        chk("timeout", "out_valid", out_valid, 1);
        chk("timeout", "out_err", out_err, 1);
        chk("timeout", "out_cos", out_cos, 0);
        chk("timeout", "out_sin", out_sin, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("timeout", "drained", out_valid, 0);

        // Backpressure: result held 10 cycles while a new request waits.
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = 16'd13500;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cd_x_out  = 14'sd2896;
        cd_y_out  = 14'sd2896;
        cd_finish = 1'b1;
        @(negedge clk);
        cd_finish = 1'b0;
        in_valid  = 1'b1;
        in_angle  = 16'd9000;
        flag = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (out_valid !== 1'b1 || out_cos !== -14'sd2896 || out_sin !== 14'sd2896 ||
                out_err !== 1'b0 || in_ready !== 1'b0) flag = 1'b0;
            @(negedge clk);
        end
        chk("bp", "stable", flag, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp", "out_valid_drop", out_valid, 0);
        chk("bp", "in_ready_after", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp", "accepted", in_ready, 0);
        @(negedge clk);
        chk("bp", "cd_start", cd_start, 1);
        chk("bp", "cd_z", cd_z, 0);
        @(negedge clk);
        cd_x_out  = 14'sd4096;
        cd_y_out  = 14'sd0;
        cd_finish = 1'b1;
        @(negedge clk);
        cd_finish = 1'b0;
        chk("bp", "out_cos", out_cos, 0);
        chk("bp", "out_sin", out_sin, 4096);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset three cycles into WAIT abandons the request; a stray finish is ignored.
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = 16'd13500;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst", "in_ready", in_ready, 1);
        chk("rst", "out_valid", out_valid, 0);
        chk("rst", "cd_z", cd_z, 0);
        cd_x_out  = 14'sd4096;
        cd_finish = 1'b1;
        @(negedge clk);
        cd_finish = 1'b0;
        cd_x_out  = '0;
        flag = 1'b0;
        repeat (TO + 8) begin
            @(negedge clk);
            if (out_valid) flag = 1'b1;
        end
        chk("rst", "no_result", flag, 0);
        request("after_rst", 9000, 0, 4096, 0, 0, 4096, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
